register_file_scoreboard: RTL and testbench

//  Consumer of the decoder's registerS/registerM/registerT indices: 16x16 register file (R0-R7, IH, SP, RA)

---
 rtl/naive_cpu_pkg.sv | 18 +
 rtl/register_file_scoreboard_if.sv | 33 +++
 rtl/register_file_scoreboard_reg_scoreboard.sv | 71 +++++++
 rtl/register_file_scoreboard.sv | 59 +++++
 tb/tb_register_file_scoreboard.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/naive_cpu_pkg.sv
// rtl/naive_cpu_pkg.sv - shared register-index constants and helpers for the register file scoreboard
package naive_cpu_pkg;

  localparam int DATA_W = 16;
  localparam int NUM_REGS = 16;
  localparam int PEND_W = 2;
  localparam logic [15:0] SP_INIT = 16'hBF10;

  localparam logic [3:0] REG_IH = 4'd8;
  localparam logic [3:0] REG_SP = 4'd9;
  localparam logic [3:0] REG_RA = 4'd10;
  localparam logic [3:0] REG_FIRST_RSVD = 4'd11;

  function automatic logic is_rsvd(input logic [3:0] idx);
    return idx >= REG_FIRST_RSVD;
  endfunction

endpackage

// File: rtl/register_file_scoreboard_if.sv
// rtl/register_file_scoreboard_if.sv - decode/execute side bus of the register file scoreboard
interface register_file_scoreboard_if #(
  parameter int DATA_W = 16
);

  logic [3:0]        rd_s_idx;
  logic [3:0]        rd_m_idx;
  logic [DATA_W-1:0] rd_s_data;
  logic [DATA_W-1:0] rd_m_data;
  logic              issue_valid;
  logic              issue_t_we;
  logic [3:0]        issue_t_idx;
  logic              wb_valid;
  logic [3:0]        wb_idx;
  logic [DATA_W-1:0] wb_data;
  logic              stall;
  logic              wb_underflow;
  logic [3:0]        dbg_idx;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output rd_s_idx, rd_m_idx, issue_valid, issue_t_we, issue_t_idx,
    output wb_valid, wb_idx, wb_data, dbg_idx,
    input  rd_s_data, rd_m_data, stall, wb_underflow, dbg_data
  );

  modport slave (
    input  rd_s_idx, rd_m_idx, issue_valid, issue_t_we, issue_t_idx,
    input  wb_valid, wb_idx, wb_data, dbg_idx,
    output rd_s_data, rd_m_data, stall, wb_underflow, dbg_data
  );

endinterface

// File: rtl/register_file_scoreboard_reg_scoreboard.sv
// rtl/register_file_scoreboard_reg_scoreboard.sv - per-register pending-write counters, stall and underflow flag
// Optional WRITE_BYPASS_EN: a completing write-back releases the source stall in the same cycle.
module reg_scoreboard
  import naive_cpu_pkg::*;
#(
  parameter int PEND_W = naive_cpu_pkg::PEND_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rd_s_idx,
  input  logic [3:0] rd_m_idx,
  input  logic       issue_valid,
  input  logic       issue_t_we,
  input  logic [3:0] issue_t_idx,
  input  logic       wb_valid,
  input  logic [3:0] wb_idx,
  output logic       stall,
  output logic       wb_underflow
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [PEND_W-1:0]   pend [NUM_REGS];
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;
  logic                issue_fire;
  logic                wb_fire;
  logic                s_busy;
  logic                m_busy;
  logic                t_full;

  assign issue_fire = issue_valid && issue_t_we && !stall && !is_rsvd(issue_t_idx);
  assign wb_fire    = wb_valid && !is_rsvd(wb_idx);

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue_fire) inc_vec[issue_t_idx] = 1'b1;
    if (wb_fire)    dec_vec[wb_idx]      = 1'b1;
  end

  always_comb begin
    s_busy = !is_rsvd(rd_s_idx) && (pend[rd_s_idx] != '0);
    m_busy = !is_rsvd(rd_m_idx) && (pend[rd_m_idx] != '0);
`ifdef WRITE_BYPASS_EN
    // The write landing now is forwarded, so only writes behind it still block.
    if (wb_fire && (wb_idx == rd_s_idx)) s_busy = pend[rd_s_idx] > PEND_ONE;
    if (wb_fire && (wb_idx == rd_m_idx)) m_busy = pend[rd_m_idx] > PEND_ONE;
`endif
    t_full = issue_t_we && !is_rsvd(issue_t_idx) && (pend[issue_t_idx] == PEND_MAX);
    stall  = s_busy || m_busy || t_full;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) pend[i] <= '0;
      wb_underflow <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        case ({inc_vec[i], dec_vec[i]})
          2'b10:   pend[i] <= pend[i] + PEND_ONE;
          2'b01:   if (pend[i] != '0) pend[i] <= pend[i] - PEND_ONE;
          default: pend[i] <= pend[i];
        endcase
      end
      if (wb_fire && !inc_vec[wb_idx] && (pend[wb_idx] == '0)) wb_underflow <= 1'b1;
    end
  end

endmodule

// File: rtl/register_file_scoreboard.sv
// rtl/register_file_scoreboard.sv - 16x16 register file with two read ports, write-back and pending-write scoreboard
// Optional WRITE_BYPASS_EN: write-back data is forwarded to the read ports in the same cycle.
module register_file_scoreboard
  import naive_cpu_pkg::*;
#(
  parameter int                DATA_W  = naive_cpu_pkg::DATA_W,
  parameter int                PEND_W  = naive_cpu_pkg::PEND_W,
  parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(naive_cpu_pkg::SP_INIT)
) (
  input logic                  clk,
  input logic                  rst,
  register_file_scoreboard_if.slave bus
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] rd_s;
  logic [DATA_W-1:0] rd_m;
  logic              wb_fire;

  assign wb_fire = bus.wb_valid && !is_rsvd(bus.wb_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= (4'(i) == REG_SP) ? SP_INIT : '0;
    end else if (wb_fire) begin
      regs[bus.wb_idx] <= bus.wb_data;
    end
  end

  always_comb begin
    rd_s = is_rsvd(bus.rd_s_idx) ? '0 : regs[bus.rd_s_idx];
    rd_m = is_rsvd(bus.rd_m_idx) ? '0 : regs[bus.rd_m_idx];
`ifdef WRITE_BYPASS_EN
    if (wb_fire && (bus.wb_idx == bus.rd_s_idx)) rd_s = bus.wb_data;
    if (wb_fire && (bus.wb_idx == bus.rd_m_idx)) rd_m = bus.wb_data;
`endif
  end

  assign bus.rd_s_data = rd_s;
  assign bus.rd_m_data = rd_m;
  assign bus.dbg_data  = is_rsvd(bus.dbg_idx) ? '0 : regs[bus.dbg_idx];

  reg_scoreboard #(
    .PEND_W(PEND_W)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .rd_s_idx     (bus.rd_s_idx),
    .rd_m_idx     (bus.rd_m_idx),
    .issue_valid  (bus.issue_valid),
    .issue_t_we   (bus.issue_t_we),
    .issue_t_idx  (bus.issue_t_idx),
    .wb_valid     (bus.wb_valid),
    .wb_idx       (bus.wb_idx),
    .stall        (bus.stall),
    .wb_underflow (bus.wb_underflow)
  );

endmodule

// File: tb/tb_register_file_scoreboard.sv
// tb/tb_register_file_scoreboard.sv - directed self-checking bench for register_file_scoreboard
module tb_register_file_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  register_file_scoreboard_if #(.DATA_W(16)) bus ();

  register_file_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.rd_s_idx    = 4'd0;
    bus.rd_m_idx    = 4'd0;
    bus.issue_valid = 1'b0;
    bus.issue_t_we  = 1'b0;
    bus.issue_t_idx = 4'd0;
    bus.wb_valid    = 1'b0;
    bus.wb_idx      = 4'd0;
    bus.wb_data     = 16'h0000;
    bus.dbg_idx     = 4'd0;
  endtask

  task automatic issue(input logic [3:0] idx);
    bus.issue_valid = 1'b1;
    bus.issue_t_we  = 1'b1;
    bus.issue_t_idx = idx;
  endtask

  task automatic no_issue();
    bus.issue_valid = 1'b0;
    bus.issue_t_we  = 1'b0;
  endtask

  task automatic wb(input logic [3:0] idx, input logic [15:0] data);
    bus.wb_valid = 1'b1;
    bus.wb_idx   = idx;
    bus.wb_data  = data;
  endtask

  task automatic no_wb();
    bus.wb_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    settle();

    // 1: reset state
    bus.dbg_idx = 4'd9;
    settle();
    check("rst_sp", bus.dbg_data, 16'hBF10);
    bus.dbg_idx = 4'd3;
    settle();
    check("rst_r3", bus.dbg_data, 16'h0000);
    check("rst_stall", bus.stall, 1'b0);
    check("rst_uflow", bus.wb_underflow, 1'b0);

    // 2: reserved write ignored, then a tracked write to R3
    wb(4'd12, 16'hFFFF);
    tick();
    no_wb();
    bus.dbg_idx  = 4'd12;
    bus.rd_s_idx = 4'd12;
    settle();
    check("rsvd_dbg", bus.dbg_data, 16'h0000);
    check("rsvd_rd", bus.rd_s_data, 16'h0000);
    check("rsvd_uflow", bus.wb_underflow, 1'b0);
    check("rsvd_stall", bus.stall, 1'b0);
    bus.rd_s_idx = 4'd0;
    issue(4'd3);
    tick();
    no_issue();
    wb(4'd3, 16'h1234);
    bus.rd_s_idx = 4'd3;
    settle();
`ifdef WRITE_BYPASS_EN
    check("r3_wb_cycle_data", bus.rd_s_data, 16'h1234);
    check("r3_wb_cycle_stall", bus.stall, 1'b0);
`else
    check("r3_wb_cycle_data", bus.rd_s_data, 16'h0000);
    check("r3_wb_cycle_stall", bus.stall, 1'b1);
`endif
    tick();
    no_wb();
    settle();
    check("r3_data", bus.rd_s_data, 16'h1234);
    check("r3_stall", bus.stall, 1'b0);
    check("r3_uflow", bus.wb_underflow, 1'b0);

    // 3: RAW hazard on R2 through the M port
    bus.rd_s_idx = 4'd0;
    issue(4'd2);
    tick();
    no_issue();
    bus.rd_m_idx = 4'd2;
    settle();
    check("r2_stall", bus.stall, 1'b1);
    wb(4'd2, 16'h00AA);
    settle();
`ifdef WRITE_BYPASS_EN
    check("r2_wb_stall", bus.stall, 1'b0);
    check("r2_wb_data", bus.rd_m_data, 16'h00AA);
`else
    check("r2_wb_stall", bus.stall, 1'b1);
    check("r2_wb_data", bus.rd_m_data, 16'h0000);
`endif
    tick();
    no_wb();
    settle();
    check("r2_after_stall", bus.stall, 1'b0);
    check("r2_after_data", bus.rd_m_data, 16'h00AA);

    // 4: fill SP to the 3-deep limit, then drain
    bus.rd_m_idx = 4'd0;
    for (int i = 0; i < 3; i++) begin
      issue(4'd9);
      settle();
      check($sformatf("sp_issue%0d_stall", i), bus.stall, 1'b0);
      tick();
    end
    check("sp_full_stall", bus.stall, 1'b1);
    tick();
    check("sp_held_stall", bus.stall, 1'b1);
    bus.issue_valid = 1'b0;
    wb(4'd9, 16'h0101);
    tick();
    no_wb();
    settle();
    check("sp_two_left_full", bus.stall, 1'b0);
    no_issue();
    bus.rd_s_idx = 4'd9;
    settle();
    check("sp_two_left_busy", bus.stall, 1'b1);
    wb(4'd9, 16'h0202);
    tick();
    wb(4'd9, 16'h0303);
    tick();
    no_wb();
    settle();
    check("sp_drained_stall", bus.stall, 1'b0);
    check("sp_drained_data", bus.rd_s_data, 16'h0303);
    check("sp_drained_uflow", bus.wb_underflow, 1'b0);

    // 5: simultaneous issue and write-back, then underflow
    bus.rd_s_idx = 4'd0;
    issue(4'd5);
    tick();
    wb(4'd5, 16'h0055);
    tick();
    no_issue();
    no_wb();
    bus.rd_s_idx = 4'd5;
    settle();
    check("r5_count_kept", bus.stall, 1'b1);
    check("r5_data", bus.rd_s_data, 16'h0055);
    wb(4'd5, 16'h0056);
    tick();
    no_wb();
    settle();
    check("r5_drained", bus.stall, 1'b0);
    check("r5_uflow", bus.wb_underflow, 1'b0);
    wb(4'd6, 16'h0066);
    tick();
    no_wb();
    settle();
    check("r6_uflow_set", bus.wb_underflow, 1'b1);
    tick();
    check("r6_uflow_held", bus.wb_underflow, 1'b1);

    // 6: reset with a write in flight
    bus.rd_s_idx = 4'd0;
    issue(4'd1);
    tick();
    no_issue();
    wb(4'd1, 16'h1111);
    tick();
    issue(4'd1);
    no_wb();
    tick();
    no_issue();
    bus.rd_s_idx = 4'd1;
    settle();
    check("r1_busy", bus.stall, 1'b1);
    rst = 1'b1;
    wb(4'd1, 16'h2222);
    tick();
    rst = 1'b0;
    no_wb();
    bus.dbg_idx = 4'd9;
    settle();
    check("mid_rst_stall", bus.stall, 1'b0);
    check("mid_rst_r1", bus.rd_s_data, 16'h0000);
    check("mid_rst_uflow", bus.wb_underflow, 1'b0);
    check("mid_rst_sp", bus.dbg_data, 16'hBF10);
    wb(4'd1, 16'h7777);
    tick();
    no_wb();
    settle();
    check("stray_wb_uflow", bus.wb_underflow, 1'b1);
    check("stray_wb_data", bus.rd_s_data, 16'h7777);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
